// File: rtl/layered_priority_renderer.sv
// ============================================================================
// layered_priority_renderer: priority-resolved layer hits -> palette RGB, 2-clk pipeline
// Optional macro RENDERER_HIT_FLASH_EN: frame-timed background hit flash
// Revision: 1.0
// ============================================================================
`default_nettype none

module layered_priority_renderer #(
  parameter int N_LAYERS     = 4,
  parameter int CW           = 4,
  parameter int FLASH_FRAMES = 30,
  parameter int BG_TINT      = 1,
  localparam int AW          = $clog2(N_LAYERS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                blank,
  input  logic                frame_start,
  input  logic [N_LAYERS-1:0] layer_hit,
  input  logic                is_trigger_player,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [3*CW-1:0]     cfg_data,
  output logic [CW-1:0]       RED,
  output logic [CW-1:0]       GREEN,
  output logic [CW-1:0]       BLUE,
  output logic                out_blank
);

  localparam logic [AW-1:0] c_BG_SEL = AW'(N_LAYERS);

  logic [3*CW-1:0] r_pal [0:N_LAYERS];
  logic [AW-1:0]   w_sel;
  logic [AW-1:0]   r_sel;
  logic            r_blank_d;
  logic            r_tint_d;
  logic            w_tint;
  logic [3*CW-1:0] w_rgb;
  logic [3*CW-1:0] r_rgb;
  logic            r_out_blank;

  // Lowest set bit wins; no hit selects the background entry.
  always_comb begin
    w_sel = c_BG_SEL;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (layer_hit[k]) w_sel = AW'(k);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_LAYERS; i++) r_pal[i] <= '1;
      r_pal[N_LAYERS] <= '0;
    end else if (cfg_we && (cfg_addr <= c_BG_SEL)) begin
      r_pal[cfg_addr] <= cfg_data;
    end
  end

`ifdef RENDERER_HIT_FLASH_EN
  logic       r_trig_q;
  logic [7:0] r_flash_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_trig_q    <= 1'b0;
      r_flash_cnt <= 8'd0;
    end else begin
      r_trig_q <= is_trigger_player;
      if (is_trigger_player && !r_trig_q)
        r_flash_cnt <= 8'(FLASH_FRAMES);
      else if (frame_start && (r_flash_cnt != 8'd0))
        r_flash_cnt <= r_flash_cnt - 8'd1;
    end
  end

  // Odd counts tint, so the flash blinks on alternate frames.
  assign w_tint = (r_flash_cnt != 8'd0) && r_flash_cnt[0];
`else
  logic w_unused;
  assign w_unused = ^{frame_start, 8'(FLASH_FRAMES)};
  assign w_tint   = is_trigger_player;
`endif

  // Blank pipeline resets to 1 so the first two pixels after release are blank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blank_d <= 1'b1;
      r_sel     <= '0;
      r_tint_d  <= 1'b0;
    end else begin
      r_blank_d <= blank;
      r_sel     <= w_sel;
      r_tint_d  <= w_tint;
    end
  end

  always_comb begin
    w_rgb = '0;
    if (!r_blank_d) begin
      if (r_sel != c_BG_SEL) begin
        w_rgb = r_pal[r_sel];
      end else begin
        w_rgb = r_pal[N_LAYERS];
        if (r_tint_d) w_rgb[3*CW-1 -: CW] = CW'(BG_TINT);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rgb       <= '0;
      r_out_blank <= 1'b1;
    end else begin
      r_rgb       <= w_rgb;
      r_out_blank <= r_blank_d;
    end
  end

  assign RED       = r_rgb[3*CW-1 -: CW];
  assign GREEN     = r_rgb[2*CW-1 -: CW];
  assign BLUE      = r_rgb[CW-1:0];
  assign out_blank = r_out_blank;

endmodule

`default_nettype wire
